sun_sensor_sequencer: RTL

APB master that drives one sun-sensor APB slave through a full frame: configure, start, stream pixels, check status, fetch the accumulated sum.
- Sits between the navigation processor's command/pixel interface and the sun-sensor peripheral.
- Software issues one start pulse per frame; the block handles every bus transfer.

---
 rtl/sun_sensor_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sun_sensor_sequencer.sv
// APB master that walks one sun-sensor slave through a frame: configuration writes,
// control write, one data write per streamed pixel, then status and sum reads.
module sun_sensor_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              reset,
  input  logic              pclk,
  input  logic              start,
  input  logic [7:0]        cfg_threshold,
  input  logic [15:0]       cfg_xmax,
  input  logic [15:0]       cfg_ymax,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              pix_ready,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata,
  input  logic              pready,
  output logic              busy,
  output logic              done,
  output logic [31:0]       sum_out,
  output logic [7:0]        status_out,
  output logic              error,
  output logic [3:0]        fsm_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_THR, S_W_XMAX, S_W_YMAX, S_W_CTRL,
    S_PIX_WAIT, S_W_PIX, S_R_STATUS, S_R_SUM, S_DONE
  } state_t;

  // Each bus state runs SETUP, ACCESS (held until pready), then one idle GAP cycle.
  typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_GAP} phase_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nx;
  phase_t        phase, phase_nx;
  logic [7:0]    thr_q, pix_q, reg_addr;
  logic [15:0]   xmax_q, ymax_q, pix_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          is_xfer, in_access, xfer_done, tmo_hit, accept, pix_hs;

  assign accept    = (state == S_IDLE) && start;
  assign pix_hs    = (state == S_PIX_WAIT) && pix_valid;
  assign in_access = is_xfer && (phase == PH_ACCESS);
  assign xfer_done = in_access && pready;
  assign tmo_hit   = in_access && !pready && (tmo_cnt == TMO_LAST);

  assign psel      = is_xfer && (phase != PH_GAP);
  assign penable   = in_access;
  assign pix_ready = (state == S_PIX_WAIT);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign paddr     = ADDR_W'(reg_addr);
  assign fsm_state = state;

  always_comb begin
    is_xfer  = 1'b1;
    reg_addr = 8'h00;
    pwrite   = 1'b0;
    pwdata   = 32'h0;
    case (state)
      S_W_THR:    begin reg_addr = 8'h01; pwrite = 1'b1; pwdata = {24'h0, thr_q}; end
      S_W_XMAX:   begin reg_addr = 8'h02; pwrite = 1'b1; pwdata = {16'h0, xmax_q}; end
      S_W_YMAX:   begin reg_addr = 8'h03; pwrite = 1'b1; pwdata = {16'h0, ymax_q}; end
      S_W_CTRL:   begin reg_addr = 8'h00; pwrite = 1'b1; pwdata = 32'h1; end
      S_W_PIX:    begin reg_addr = 8'h04; pwrite = 1'b1; pwdata = {24'h0, pix_q}; end
      S_R_STATUS: reg_addr = 8'h05;
      S_R_SUM:    reg_addr = 8'h06;
      default:    is_xfer = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    case (state)
      S_IDLE: if (start) begin state_nx = S_W_THR; phase_nx = PH_SETUP; end
      S_PIX_WAIT: if (pix_valid) begin state_nx = S_W_PIX; phase_nx = PH_SETUP; end
      S_DONE: state_nx = S_IDLE;
      default: begin
        case (phase)
          PH_SETUP: phase_nx = PH_ACCESS;
          PH_ACCESS: begin
            if (pready) begin
              phase_nx = PH_GAP;
            end else if (tmo_cnt == TMO_LAST) begin
              state_nx = S_DONE;
              phase_nx = PH_SETUP;
            end
          end
          default: begin
            phase_nx = PH_SETUP;
            case (state)
              S_W_THR:    state_nx = S_W_XMAX;
              S_W_XMAX:   state_nx = S_W_YMAX;
              S_W_YMAX:   state_nx = S_W_CTRL;
              S_W_CTRL:   state_nx = (xmax_q == 16'h0) ? S_R_STATUS : S_PIX_WAIT;
              S_W_PIX:    state_nx = (pix_cnt == xmax_q) ? S_R_STATUS : S_PIX_WAIT;
              S_R_STATUS: state_nx = S_R_SUM;
              default:    state_nx = S_DONE;
            endcase
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= PH_SETUP;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      thr_q      <= 8'h0;
      xmax_q     <= 16'h0;
      ymax_q     <= 16'h0;
      pix_q      <= 8'h0;
      pix_cnt    <= 16'h0;
      tmo_cnt    <= '0;
      sum_out    <= 32'h0;
      status_out <= 8'h0;
      error      <= 1'b0;
    end else begin
      if (accept) begin
        thr_q   <= cfg_threshold;
        xmax_q  <= cfg_xmax;
        ymax_q  <= cfg_ymax;
        pix_cnt <= 16'h0;
        error   <= 1'b0;
      end
      if (pix_hs) begin
        pix_q   <= pix_data;
        pix_cnt <= pix_cnt + 16'h1;
      end
      if (in_access && !pready) tmo_cnt <= tmo_cnt + 1'b1;
      else                      tmo_cnt <= '0;
      // A bad status flags the frame, but the sum is still fetched.
      if (xfer_done && (state == S_R_STATUS)) begin
        status_out <= prdata[7:0];
        if (prdata[7:0] != 8'h03) error <= 1'b1;
      end
      if (xfer_done && (state == S_R_SUM)) sum_out <= prdata;
      if (tmo_hit) error <= 1'b1;
    end
  end

endmodule
